pixel_cluster_result_regs: RTL
==============================

PIXEL_CLUSTER_RESULT_REGS -- requirements
Module: pixel_cluster_result_regs

Interface
REQ-001 SHALL have parameter N_CLUSTERS, default 4, number of cluster slots from the x/y clusterer.
REQ-002 SHALL have parameter X_Y_BITS, default 16, width of each cluster X/Y centroid.
REQ-003 SHALL have parameter COUNTER_BITS, default 16, width of each cluster pixel counter.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port X_clusters  input  X_Y_BITS*N_CLUSTERS  packed centroid X; slot i at [i*X_Y_BITS +: X_Y_BITS].
REQ-007 SHALL have port Y_clusters  input  X_Y_BITS*N_CLUSTERS  packed centroid Y, same packing.
REQ-008 SHALL have port cluster_counters  input  COUNTER_BITS*N_CLUSTERS  packed per-slot pixel counts.
REQ-009 SHALL have port frame_done  input  1  one-cycle pulse after the last pixel of a frame has drained the clusterer.
REQ-010 SHALL have ports avs_address input 3, avs_read input 1, avs_write input 1, avs_writedata input 32, avs_readdata output 32 (Avalon-MM slave).
REQ-011 SHALL have port irq  output  1  level interrupt, equals irq_pending AND irq_en.

Function
REQ-012 SHALL implement FSM IDLE -> SCAN -> PUBLISH -> IDLE.
REQ-013 In IDLE, frame_done SHALL snapshot all three cluster buses into shadow registers, clear best_count/best_index to 0, and enter SCAN with index 0.
REQ-014 SCAN SHALL examine one slot per cycle, index 0..N_CLUSTERS-1; slot replaces best only if count > best_count (strict; lowest index wins ties).
REQ-015 After slot N_CLUSTERS-1, SHALL enter PUBLISH for exactly one cycle, then IDLE.
REQ-016 PUBLISH SHALL copy best X, Y, count, index into result registers, set result_valid = (best_count >= min_count), set irq_pending, increment frame_count (wraps at 2^32).
REQ-017 Latency: frame_done at cycle 0 -> result registers updated at the clock edge ending cycle N_CLUSTERS+1.
REQ-018 frame_done while in SCAN or PUBLISH SHALL be ignored for scanning and SHALL increment dropped_count (16-bit, saturating at 0xFFFF).
REQ-019 Register map (word address): 0 STATUS {busy[1]... see below}; bit0 result_valid, bit1 busy (state != IDLE), bit2 irq_pending; 1 CONTROL bit0 irq_en; 2 MIN_COUNT [COUNTER_BITS-1:0]; 3 RESULT_XY {Y[31:16], X[15:0]}; 4 RESULT_CNT {index[23:16], count[15:0]}; 5 FRAME_COUNT; 6 DROPPED; 7 reads 0.
REQ-020 Reads SHALL have fixed latency 1: avs_readdata registered, valid the cycle after avs_read; unused bits read 0.
REQ-021 Writes: CONTROL and MIN_COUNT writable; STATUS write of 1 to bit2 clears irq_pending; all other writes ignored.
REQ-022 Simultaneous PUBLISH and irq_pending clear write SHALL leave irq_pending = 1 (set wins).
REQ-023 Simultaneous read and write to same address SHALL return pre-write value.

Reset
REQ-024 reset SHALL force IDLE, clear shadows, results, result_valid, irq_pending, irq_en, frame_count, dropped_count, avs_readdata, irq to 0, and MIN_COUNT to 1.
REQ-025 reset asserted mid-SCAN SHALL abandon the scan with no PUBLISH and no counter change.

Configuration
REQ-026 Macro PIXEL_CLUSTER_DROP_COUNT_EN: defined -> dropped_count implemented per REQ-018; undefined -> no counter register, address 6 reads 0, all else identical.

Structure
REQ-027 Package pixel_cluster_pkg SHALL hold the FSM state enum and register address constants (ADDR_STATUS..ADDR_DROPPED).
REQ-028 Sub-module pixel_cluster_argmax SHALL contain the SCAN index counter and best-slot compare; top holds snapshot, Avalon-MM and IRQ logic.

Verification
REQ-029 Counts {0,3,2,1} (slot3..0 = 0,3,2,1), X slot2=15, Y slot2=15, frame_done -> after 6 cycles RESULT_XY=0x000F000F, RESULT_CNT index=2 count=3, result_valid=1.
REQ-030 Counts all 5, MIN_COUNT=1 -> index 0 selected (tie rule); MIN_COUNT=6 -> same result, result_valid=0.
REQ-031 irq_en=1, frame_done -> irq=1 after PUBLISH; write STATUS 0x4 -> irq=0 next cycle; clear in PUBLISH cycle -> irq stays 1.
REQ-032 frame_done at cycles 0 and 2 -> one PUBLISH, FRAME_COUNT=1, DROPPED=1 (0 when macro undefined).
REQ-033 reset asserted at cycle 2 of SCAN -> STATUS=0, FRAME_COUNT=0, MIN_COUNT=1, no irq.
REQ-034 Read each address -> value appears exactly one cycle after avs_read; address 7 reads 0.

Source files
------------

// File: rtl/pixel_cluster_pkg.sv
// Shared types and register map for the pixel cluster result block.
// State encoding and Avalon-MM word addresses.
package pixel_cluster_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PUBLISH
  } state_t;

  localparam logic [2:0] ADDR_STATUS      = 3'd0;
  localparam logic [2:0] ADDR_CONTROL     = 3'd1;
  localparam logic [2:0] ADDR_MIN_COUNT   = 3'd2;
  localparam logic [2:0] ADDR_RESULT_XY   = 3'd3;
  localparam logic [2:0] ADDR_RESULT_CNT  = 3'd4;
  localparam logic [2:0] ADDR_FRAME_COUNT = 3'd5;
  localparam logic [2:0] ADDR_DROPPED     = 3'd6;

endpackage

// File: rtl/pixel_cluster_result_regs_if.sv
// Avalon-MM register port bundle for the pixel cluster result block.
// master drives commands, slave returns registered read data.
interface pixel_cluster_result_regs_if;

  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/pixel_cluster_argmax.sv
// Sequential argmax over cluster slots: one slot per cycle.
// Strict compare, so the lowest index keeps a tie.
module pixel_cluster_argmax
  import pixel_cluster_pkg::*;
#(
  parameter int N_CLUSTERS   = 4,
  parameter int COUNTER_BITS = 16,
  parameter int IW = (N_CLUSTERS > 1) ? $clog2(N_CLUSTERS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               scan,
  input  logic [COUNTER_BITS*N_CLUSTERS-1:0] counts,
  output logic                               last,
  output logic [IW-1:0]                      best_idx,
  output logic [COUNTER_BITS-1:0]            best_count
);

  logic [IW-1:0]           idx;
  logic [COUNTER_BITS-1:0] cur;

  assign cur  = counts[idx*COUNTER_BITS +: COUNTER_BITS];
  assign last = (idx == IW'(N_CLUSTERS - 1));

  always_ff @(posedge clk) begin
    if (reset || start) begin
      idx        <= '0;
      best_idx   <= '0;
      best_count <= '0;
    end else if (scan) begin
      idx <= last ? '0 : idx + 1'b1;
      if (cur > best_count) begin
        best_idx   <= idx;
        best_count <= cur;
      end
    end
  end

endmodule

// File: rtl/pixel_cluster_result_regs.sv
// Frame result registers: snapshot, argmax scan, publish, Avalon-MM, IRQ.
// Define PIXEL_CLUSTER_DROP_COUNT_EN to build the dropped-frame counter.
module pixel_cluster_result_regs
  import pixel_cluster_pkg::*;
#(
  parameter int N_CLUSTERS   = 4,
  parameter int X_Y_BITS     = 16,
  parameter int COUNTER_BITS = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [X_Y_BITS*N_CLUSTERS-1:0]     X_clusters,
  input  logic [X_Y_BITS*N_CLUSTERS-1:0]     Y_clusters,
  input  logic [COUNTER_BITS*N_CLUSTERS-1:0] cluster_counters,
  input  logic                               frame_done,
  pixel_cluster_result_regs_if.slave         avs,
  output logic                               irq
);

  localparam int IW = (N_CLUSTERS > 1) ? $clog2(N_CLUSTERS) : 1;

  state_t state_q, state_d;
  logic   start, scan, publish, last;

  logic [X_Y_BITS*N_CLUSTERS-1:0]     x_sh, y_sh;
  logic [COUNTER_BITS*N_CLUSTERS-1:0] c_sh;

  logic [IW-1:0]           best_idx;
  logic [COUNTER_BITS-1:0] best_count;
  logic [X_Y_BITS-1:0]     best_x, best_y;

  logic [X_Y_BITS-1:0]     res_x, res_y;
  logic [COUNTER_BITS-1:0] res_cnt, min_count;
  logic [IW-1:0]           res_idx;
  logic                    result_valid, irq_pending, irq_en;
  logic [31:0]             frame_count, dropped_rd, rd_data;
  logic                    wr_status, wr_control, wr_min;
  logic                    unused_wd;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    scan    = 1'b0;
    publish = 1'b0;
    unique case (state_q)
      IDLE: if (frame_done) begin
        start   = 1'b1;
        state_d = SCAN;
      end
      SCAN: begin
        scan = 1'b1;
        if (last) state_d = PUBLISH;
      end
      PUBLISH: begin
        publish = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_sh <= '0;
      y_sh <= '0;
      c_sh <= '0;
    end else if (start) begin
      x_sh <= X_clusters;
      y_sh <= Y_clusters;
      c_sh <= cluster_counters;
    end
  end

  pixel_cluster_argmax #(
    .N_CLUSTERS   (N_CLUSTERS),
    .COUNTER_BITS (COUNTER_BITS),
    .IW           (IW)
  ) u_argmax (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .scan       (scan),
    .counts     (c_sh),
    .last       (last),
    .best_idx   (best_idx),
    .best_count (best_count)
  );

  assign best_x = x_sh[best_idx*X_Y_BITS +: X_Y_BITS];
  assign best_y = y_sh[best_idx*X_Y_BITS +: X_Y_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      res_x        <= '0;
      res_y        <= '0;
      res_cnt      <= '0;
      res_idx      <= '0;
      result_valid <= 1'b0;
      frame_count  <= '0;
    end else if (publish) begin
      res_x        <= best_x;
      res_y        <= best_y;
      res_cnt      <= best_count;
      res_idx      <= best_idx;
      result_valid <= (best_count >= min_count);
      frame_count  <= frame_count + 32'd1;
    end
  end

  assign wr_status  = avs.avs_write && (avs.avs_address == ADDR_STATUS);
  assign wr_control = avs.avs_write && (avs.avs_address == ADDR_CONTROL);
  assign wr_min     = avs.avs_write && (avs.avs_address == ADDR_MIN_COUNT);
  assign unused_wd  = ^avs.avs_writedata[31:COUNTER_BITS];

  // A publish in the same cycle as a clear leaves the interrupt pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en      <= 1'b0;
      min_count   <= COUNTER_BITS'(1);
      irq_pending <= 1'b0;
    end else begin
      if (wr_control) irq_en <= avs.avs_writedata[0];
      if (wr_min) min_count <= avs.avs_writedata[COUNTER_BITS-1:0];
      if (publish) irq_pending <= 1'b1;
      else if (wr_status && avs.avs_writedata[2]) irq_pending <= 1'b0;
    end
  end

  assign irq = irq_pending & irq_en;

`ifdef PIXEL_CLUSTER_DROP_COUNT_EN
  logic [15:0] dropped_count;

  always_ff @(posedge clk) begin
    if (reset) dropped_count <= '0;
    else if (frame_done && state_q != IDLE && dropped_count != 16'hFFFF)
      dropped_count <= dropped_count + 16'd1;
  end

  assign dropped_rd = {16'h0, dropped_count};
`else
  assign dropped_rd = '0;
`endif

  always_comb begin
    rd_data = '0;
    unique case (avs.avs_address)
      ADDR_STATUS:
        rd_data = {29'h0, irq_pending, state_q != IDLE, result_valid};
      ADDR_CONTROL:     rd_data = {31'h0, irq_en};
      ADDR_MIN_COUNT:   rd_data = 32'(min_count);
      ADDR_RESULT_XY:   rd_data = {16'(res_y), 16'(res_x)};
      ADDR_RESULT_CNT:  rd_data = {8'h0, 8'(res_idx), 16'(res_cnt)};
      ADDR_FRAME_COUNT: rd_data = frame_count;
      ADDR_DROPPED:     rd_data = dropped_rd;
      default:          rd_data = '0;
    endcase
  end

  // Sampled before this edge's writes land, so read-during-write sees old data.
  always_ff @(posedge clk) begin
    if (reset)         avs.avs_readdata <= '0;
    else if (avs.avs_read) avs.avs_readdata <= rd_data;
  end

endmodule
